// File: rtl/cmd_physical_pkg.sv
// Shared constants, one-hot state encoding and the CRC7 step for the SD CMD line PHY.
package cmd_physical_pkg;

  localparam int FRAME_W = 48;
  localparam int CMD_W   = 38;
  localparam int HDR_W   = 40;
  localparam int BIT_W   = 6;
  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_SEND      = 6'b000010,
    ST_WAIT_RESP = 6'b000100,
    ST_RECEIVE   = 6'b001000,
    ST_HANDOFF   = 6'b010000,
    ST_RELEASE   = 6'b100000
  } state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/cmd_crc7.sv
// Serial CRC7 accumulator: clear has priority, then one data bit per enabled cycle.
module cmd_crc7
  import cmd_physical_pkg::*;
(
  input  logic       CLK_SD,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);

  logic [6:0] crc_reg;

  always_ff @(posedge CLK_SD) begin
    if (reset || clear) begin
      crc_reg <= '0;
    end else if (enable) begin
      crc_reg <= crc7_step(crc_reg, data);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/cmd_physical.sv
// SD CMD line PHY: frames a command with CRC7, shifts it out, captures the 48-bit response.
// Optional receive CRC check enabled by defining CMD_PHY_CRC_CHECK_EN.
module cmd_physical
  import cmd_physical_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                CLK_SD,
  input  logic                reset,
  input  logic                REQ_in,
  input  logic                ACK_in,
  input  logic [CMD_W-1:0]    cmd_to_send,
  input  logic                cmd_in,
  output logic                cmd_out,
  output logic                cmd_oe,
  output logic                ACK_out,
  output logic                REQ_out,
  output logic [FRAME_W-1:0]  cmd_response,
  output logic                timeout_error,
  output logic                crc_error,
  output logic                physical_inactive
);

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(RESP_TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [CMD_W-1:0]     cmd_reg, cmd_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0]        wait_cnt_reg, wait_cnt_next;
  logic [FRAME_W-2:0]   rx_shift_reg, rx_shift_next;
  logic                 cmd_out_reg, cmd_out_next;
  logic                 cmd_oe_reg, cmd_oe_next;
  logic                 ack_out_reg, ack_out_next;
  logic                 req_out_reg, req_out_next;
  logic [FRAME_W-1:0]   resp_reg, resp_next;
  logic                 timeout_reg, timeout_next;
  logic                 crc_err_reg, crc_err_next;
  logic                 inactive_reg;

  logic                 tx_clear, tx_en, tx_din;
  logic [6:0]           tx_crc;
  logic [BIT_W-1:0]     load_idx;
  logic [HDR_W-1:0]     hdr;
  logic                 next_bit;

  // The start bit is 0 and the CRC starts at 0, so clearing at acceptance equals absorbing bit 47.
  cmd_crc7 u_tx_crc (
    .CLK_SD (CLK_SD),
    .reset  (reset),
    .clear  (tx_clear),
    .enable (tx_en),
    .data   (tx_din),
    .crc    (tx_crc)
  );

`ifdef CMD_PHY_CRC_CHECK_EN
  logic       rx_clear, rx_en, rx_din;
  logic [6:0] rx_crc;

  cmd_crc7 u_rx_crc (
    .CLK_SD (CLK_SD),
    .reset  (reset),
    .clear  (rx_clear),
    .enable (rx_en),
    .data   (rx_din),
    .crc    (rx_crc)
  );
`endif

  // Bit about to be loaded onto the line; the CRC absorbs it in the same cycle.
  always_comb begin
    load_idx = bit_cnt_reg - 6'd1;
    hdr      = {2'b01, cmd_reg};
    next_bit = 1'b1;
    if (load_idx >= 6'd8) begin
      next_bit = hdr[load_idx - 6'd8];
    end else if (load_idx != 6'd0) begin
      next_bit = tx_crc[load_idx[2:0] - 3'd1];
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    rx_shift_next = rx_shift_reg;
    cmd_out_next  = cmd_out_reg;
    cmd_oe_next   = cmd_oe_reg;
    ack_out_next  = ack_out_reg;
    req_out_next  = req_out_reg;
    resp_next     = resp_reg;
    timeout_next  = timeout_reg;
    crc_err_next  = crc_err_reg;
    tx_clear      = 1'b0;
    tx_en         = 1'b0;
    tx_din        = 1'b0;
`ifdef CMD_PHY_CRC_CHECK_EN
    rx_clear      = 1'b0;
    rx_en         = 1'b0;
    rx_din        = cmd_in;
`endif

    case (state_reg)
      ST_IDLE: begin
        cmd_oe_next  = 1'b0;
        cmd_out_next = 1'b1;
        if (REQ_in) begin
          cmd_next     = cmd_to_send;
          timeout_next = 1'b0;
          crc_err_next = 1'b0;
          ack_out_next = 1'b1;
          cmd_oe_next  = 1'b1;
          cmd_out_next = 1'b0;
          bit_cnt_next = 6'd47;
          tx_clear     = 1'b1;
          state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bit_cnt_reg == 6'd0) begin
          cmd_oe_next   = 1'b0;
          cmd_out_next  = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_WAIT_RESP;
        end else begin
          cmd_out_next = next_bit;
          bit_cnt_next = load_idx;
          tx_en        = (load_idx >= 6'd8);
          tx_din       = next_bit;
        end
      end

      ST_WAIT_RESP: begin
        if (!cmd_in) begin
          rx_shift_next = '0;
          bit_cnt_next  = 6'd46;
          state_next    = ST_RECEIVE;
`ifdef CMD_PHY_CRC_CHECK_EN
          rx_clear      = 1'b1;
`endif
        end else if (wait_cnt_reg == WAIT_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_RELEASE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_RECEIVE: begin
`ifdef CMD_PHY_CRC_CHECK_EN
        rx_en = (bit_cnt_reg >= 6'd8);
`endif
        if (bit_cnt_reg == 6'd0) begin
          resp_next  = {rx_shift_reg, cmd_in};
          state_next = ST_HANDOFF;
        end else begin
          rx_shift_next = {rx_shift_reg[FRAME_W-3:0], cmd_in};
          bit_cnt_next  = bit_cnt_reg - 6'd1;
        end
      end

      ST_HANDOFF: begin
        if (!req_out_reg) begin
          req_out_next = 1'b1;
`ifdef CMD_PHY_CRC_CHECK_EN
          crc_err_next = (rx_crc != resp_reg[7:1]);
`endif
        end else if (ACK_in) begin
          req_out_next = 1'b0;
          state_next   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!REQ_in) begin
          ack_out_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SD) begin
    inactive_reg <= reset;
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      rx_shift_reg <= '0;
      cmd_out_reg  <= 1'b1;
      cmd_oe_reg   <= 1'b0;
      ack_out_reg  <= 1'b0;
      req_out_reg  <= 1'b0;
      resp_reg     <= '0;
      timeout_reg  <= 1'b0;
      crc_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      rx_shift_reg <= rx_shift_next;
      cmd_out_reg  <= cmd_out_next;
      cmd_oe_reg   <= cmd_oe_next;
      ack_out_reg  <= ack_out_next;
      req_out_reg  <= req_out_next;
      resp_reg     <= resp_next;
      timeout_reg  <= timeout_next;
      crc_err_reg  <= crc_err_next;
    end
  end

  assign cmd_out           = cmd_out_reg;
  assign cmd_oe            = cmd_oe_reg;
  assign ACK_out           = ack_out_reg;
  assign REQ_out           = req_out_reg;
  assign cmd_response      = resp_reg;
  assign timeout_error     = timeout_reg;
  assign crc_error         = crc_err_reg;
  assign physical_inactive = inactive_reg;

endmodule

// File: tb/tb_cmd_physical.sv
// Bench for cmd_physical: vector table of commands/responses, scoreboard monitors on the CMD line and REQ_out.
module tb_cmd_physical;

  logic        CLK_SD = 1'b0;
  logic        reset  = 1'b1;
  logic        REQ_in = 1'b0;
  logic        ACK_in = 1'b0;
  logic        cmd_in = 1'b1;
  logic [37:0] cmd_to_send = '0;
  logic        cmd_out, cmd_oe, ACK_out, REQ_out, timeout_error, crc_error, physical_inactive;
  logic [47:0] cmd_response;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [47:0] data;
    logic        crc_err;
  } resp_exp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    int          delay;   // -1: card stays silent
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic        flip;
  } vec_t;

  logic [47:0] frame_q[$];
  resp_exp_t   resp_q[$];
  logic        abort_ok  = 1'b0;
  logic [47:0] last_resp = '0;
  vec_t        vecs[5];

  cmd_physical dut (
    .CLK_SD            (CLK_SD),
    .reset             (reset),
    .REQ_in            (REQ_in),
    .ACK_in            (ACK_in),
    .cmd_to_send       (cmd_to_send),
    .cmd_in            (cmd_in),
    .cmd_out           (cmd_out),
    .cmd_oe            (cmd_oe),
    .ACK_out           (ACK_out),
    .REQ_out           (REQ_out),
    .cmd_response      (cmd_response),
    .timeout_error     (timeout_error),
    .crc_error         (crc_error),
    .physical_inactive (physical_inactive)
  );

  always #5 CLK_SD = ~CLK_SD;

  task automatic tick();
    @(posedge CLK_SD);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_ref(h), 1'b1};
  endfunction

  function automatic logic [47:0] make_resp(input logic [5:0] idx, input logic [31:0] arg, input logic flip);
    logic [39:0] h;
    logic [47:0] t;
    h = {2'b00, idx, arg};
    t = {h, crc7_ref(h), 1'b1};
    if (flip) t[1] = ~t[1];
    return t;
  endfunction

  // CMD line monitor: collects each driven frame and checks it against the scoreboard.
  initial begin
    logic [47:0] mon;
    logic [47:0] e;
    int          mcnt;
    mon  = '0;
    mcnt = 0;
    forever begin
      tick();
      if (cmd_oe) begin
        mon = {mon[46:0], cmd_out};
        mcnt++;
      end else if (mcnt != 0) begin
        if (frame_q.size() == 0) begin
          if (!abort_ok) begin
            bad++;
            total++;
            $display("FAIL unexpected_frame: got %0d bits want none", mcnt);
          end
        end else begin
          e = frame_q.pop_front();
          chk("frame_bits", 64'(mcnt), 64'd48);
          chk("frame_data", 64'(mon), 64'(e));
        end
        mcnt = 0;
      end
    end
  end

  // Response monitor: checks the handoff on each REQ_out rise.
  initial begin
    logic      req_prev;
    resp_exp_t e;
    req_prev = 1'b0;
    forever begin
      tick();
      if (REQ_out && !req_prev) begin
        if (resp_q.size() == 0) begin
          bad++;
          total++;
          $display("FAIL unexpected_req: got REQ_out=1 want 0");
        end else begin
          e = resp_q.pop_front();
          chk("resp_data", 64'(cmd_response), 64'(e.data));
          chk("resp_crc_error", 64'(crc_error), 64'(e.crc_err));
          chk("resp_timeout", 64'(timeout_error), 64'd0);
        end
      end
      req_prev = REQ_out;
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int          n;
    logic        saw_req;
    logic        exp_crc;
    logic [47:0] tok;
    tok = make_resp(v.ridx, v.rarg, v.flip);
`ifdef CMD_PHY_CRC_CHECK_EN
    exp_crc = v.flip;
`else
    exp_crc = 1'b0;
`endif
    cmd_to_send = {v.idx, v.arg};
    REQ_in = 1'b1;
    frame_q.push_back(v.frame);
    if (v.delay >= 0) resp_q.push_back('{data: tok, crc_err: exp_crc});
    tick();
    chk("accept_ack", 64'(ACK_out), 64'd1);
    chk("accept_oe", 64'(cmd_oe), 64'd1);
    chk("accept_start", 64'(cmd_out), 64'd0);
    n = 0;
    while (cmd_oe && n < 100) begin
      tick();
      n++;
    end
    chk("send_cycles", 64'(n), 64'd48);

    if (v.delay < 0) begin
      n = 0;
      saw_req = 1'b0;
      while (!timeout_error && n < 200) begin
        tick();
        n++;
        if (REQ_out) saw_req = 1'b1;
      end
      chk("timeout_latency", 64'(n), 64'd64);
      chk("timeout_no_req", 64'(saw_req), 64'd0);
      chk("timeout_resp_hold", 64'(cmd_response), 64'(last_resp));
      REQ_in = 1'b0;
      tick();
      chk("timeout_release_ack", 64'(ACK_out), 64'd0);
      chk("timeout_flag_hold", 64'(timeout_error), 64'd1);
    end else begin
      repeat (v.delay) tick();
      for (int i = 47; i >= 0; i--) begin
        cmd_in = tok[i];
        tick();
      end
      cmd_in = 1'b1;
      chk("req_not_early", 64'(REQ_out), 64'd0);
      n = 0;
      while (!REQ_out && n < 10) begin
        tick();
        n++;
      end
      chk("req_latency", 64'(n), 64'd1);
      ACK_in = 1'b1;
      n = 0;
      while (REQ_out && n < 10) begin
        tick();
        n++;
      end
      chk("req_drop", 64'(REQ_out), 64'd0);
      ACK_in = 1'b0;
      REQ_in = 1'b0;
      tick();
      chk("release_ack", 64'(ACK_out), 64'd0);
      last_resp = tok;
    end
    tick();
    chk("idle_oe", 64'(cmd_oe), 64'd0);
    chk("idle_line", 64'(cmd_out), 64'd1);
    $display("txn %0d: CMD%0d arg=%08h delay=%0d resp=%012h timeout=%0b crc_err=%0b",
             id, v.idx, v.arg, v.delay, cmd_response, timeout_error, crc_error);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rf;
    vecs[0] = '{idx: 6'd0,  arg: 32'h0,     frame: 48'h40_0000_0000_95, delay: -1, ridx: 6'd0,  rarg: 32'h0,     flip: 1'b0};
    vecs[1] = '{idx: 6'd8,  arg: 32'h1AA,   frame: 48'h48_0000_01AA_87, delay: 3,  ridx: 6'd8,  rarg: 32'h1AA,   flip: 1'b0};
    vecs[2] = '{idx: 6'd17, arg: 32'h0,     frame: make_cmd(6'd17, 32'h0), delay: 0, ridx: 6'd17, rarg: 32'h900, flip: 1'b0};
    vecs[3] = '{idx: 6'd55, arg: 32'h12340000, frame: make_cmd(6'd55, 32'h12340000), delay: 63, ridx: 6'd55, rarg: 32'h120, flip: 1'b0};
    vecs[4] = '{idx: 6'd8,  arg: 32'h1AA,   frame: 48'h48_0000_01AA_87, delay: 10, ridx: 6'd8,  rarg: 32'h1AA,   flip: 1'b1};

    repeat (3) tick();
    chk("rst_cmd_out", 64'(cmd_out), 64'd1);
    chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("rst_ack_out", 64'(ACK_out), 64'd0);
    chk("rst_req_out", 64'(REQ_out), 64'd0);
    chk("rst_response", 64'(cmd_response), 64'd0);
    chk("rst_timeout", 64'(timeout_error), 64'd0);
    chk("rst_crc_error", 64'(crc_error), 64'd0);
    chk("rst_inactive", 64'(physical_inactive), 64'd1);
    reset = 1'b0;
    tick();
    chk("inactive_fall", 64'(physical_inactive), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset while bit 20 of the frame is on the line.
    rf = make_cmd(6'd17, 32'hDEADBEEF);
    abort_ok = 1'b1;
    cmd_to_send = {6'd17, 32'hDEADBEEF};
    REQ_in = 1'b1;
    tick();
    repeat (27) tick();
    chk("midsend_bit20", 64'(cmd_out), 64'(rf[20]));
    reset = 1'b1;
    tick();
    chk("midrst_oe", 64'(cmd_oe), 64'd0);
    chk("midrst_line", 64'(cmd_out), 64'd1);
    chk("midrst_ack", 64'(ACK_out), 64'd0);
    chk("midrst_inactive", 64'(physical_inactive), 64'd1);
    chk("midrst_req", 64'(REQ_out), 64'd0);
    REQ_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_inactive", 64'(physical_inactive), 64'd0);
    abort_ok = 1'b0;
    last_resp = '0;
    $display("txn 5: reset during SEND bit 20");
    run_vec(6, vecs[1]);

    repeat (3) tick();
    chk("queues_drained", 64'(frame_q.size() + resp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
